// File: rtl/unidade_controle_jogo_pkg.sv
// Shared definitions for the game control unit: state encoding and default pause length.
package unidade_controle_jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL   = 4'h0,
        PREPARA   = 4'h1,
        JOGANDO   = 4'h3,
        PAUSA     = 4'h4,
        AVALIA    = 4'h5,
        PROXIMO   = 4'h6,
        RECARREGA = 4'h7,
        FIM       = 4'h8
    } estado_t;

    localparam int PAUSA_CICLOS_PADRAO = 50_000_000;

endpackage

// File: rtl/unidade_controle_jogo_contador_pausa.sv
// Pause timer: up-counter with synchronous clear, enable and terminal-count flag.
module contador_pausa #(
    parameter int N = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       limpa,
    input  logic                       habilita,
    output logic [$clog2(N+1)-1:0]     contagem,
    output logic                       fim
);

    localparam int W = $clog2(N + 1);

    logic [W-1:0] cont_q;
    logic [W-1:0] cont_d;

    assign fim      = (cont_q == W'(N - 1));
    assign contagem = cont_q;

    // Holding at the terminal count keeps the timer from ever wrapping.
    always_comb begin
        cont_d = cont_q;
        if (limpa) begin
            cont_d = '0;
        end else if (habilita && !fim) begin
            cont_d = cont_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

endmodule

// File: rtl/unidade_controle_jogo.sv
// Game control FSM: clears the datapath, plays a level, pauses, then
// advances to the next level or finishes.
module unidade_controle_jogo
    import unidade_controle_jogo_pkg::*;
#(
    parameter int PAUSA_CICLOS = PAUSA_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       nivel_concluido,
    input  logic       nivelIgualUltimoNivel,
    output logic       zeraN,
    output logic       zeraM,
    output logic       contaN,
    output logic       em_jogo,
    output logic       pronto,
    output logic [3:0] db_estado
);

    estado_t estado_q;
    estado_t estado_d;
    logic    pausa_fim;
    logic    em_pausa;

    logic [$clog2(PAUSA_CICLOS+1)-1:0] pausa_cont;

    assign em_pausa = (estado_q == PAUSA);

    contador_pausa #(
        .N (PAUSA_CICLOS)
    ) u_pausa (
        .clock    (clock),
        .reset    (reset),
        .limpa    (!em_pausa),
        .habilita (em_pausa),
        .contagem (pausa_cont),
        .fim      (pausa_fim)
    );

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:   if (iniciar) estado_d = PREPARA;
            PREPARA:   estado_d = JOGANDO;
            JOGANDO:   if (nivel_concluido) estado_d = PAUSA;
            PAUSA:     if (pausa_fim) estado_d = AVALIA;
            AVALIA:    estado_d = nivelIgualUltimoNivel ? FIM : PROXIMO;
            PROXIMO:   estado_d = RECARREGA;
            RECARREGA: estado_d = JOGANDO;
            FIM:       if (iniciar) estado_d = PREPARA;
            default:   estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        zeraN   = 1'b0;
        zeraM   = 1'b0;
        contaN  = 1'b0;
        em_jogo = 1'b0;
        pronto  = 1'b0;
        case (estado_q)
            PREPARA: begin
                zeraN = 1'b1;
                zeraM = 1'b1;
            end
            JOGANDO:   em_jogo = 1'b1;
            PAUSA:     em_jogo = 1'b1;
            PROXIMO:   contaN  = 1'b1;
            RECARREGA: zeraM   = 1'b1;
            FIM:       pronto  = 1'b1;
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Self-checking bench for the game control FSM with a short pause.
module tb_unidade_controle_jogo;

    localparam int P = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       nivel_concluido;
    logic       nivelIgualUltimoNivel;
    logic       zeraN;
    logic       zeraM;
    logic       contaN;
    logic       em_jogo;
    logic       pronto;
    logic [3:0] db_estado;

    int checks   = 0;
    int failures = 0;
    int n_conta  = 0;
    bit chk_en   = 1'b0;

    int m_s = 0;
    int m_t = 0;

    unidade_controle_jogo #(
        .PAUSA_CICLOS (P)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .iniciar               (iniciar),
        .nivel_concluido       (nivel_concluido),
        .nivelIgualUltimoNivel (nivelIgualUltimoNivel),
        .zeraN                 (zeraN),
        .zeraM                 (zeraM),
        .contaN                (contaN),
        .em_jogo               (em_jogo),
        .pronto                (pronto),
        .db_estado             (db_estado)
    );

    always #5 clock = ~clock;

    // Reference model: state table from the game rules, pause tracked as a count.
    function automatic int prox(int s, int t, logic ini, logic nc, logic ult);
        case (s)
            0:       return ini ? 1 : 0;
            1:       return 3;
            3:       return nc ? 4 : 3;
            4:       return (t == P - 1) ? 5 : 4;
            5:       return ult ? 8 : 6;
            6:       return 7;
            7:       return 3;
            8:       return ini ? 1 : 8;
            default: return 0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_s <= 0;
            m_t <= 0;
        end else begin
            m_s <= prox(m_s, m_t, iniciar, nivel_concluido,
                        nivelIgualUltimoNivel);
            m_t <= (m_s == 4 && m_t != P - 1) ? m_t + 1 : 0;
        end
    end

    always @(negedge clock) begin
        logic [8:0] exp_v;
        logic [8:0] act_v;
        if (chk_en) begin
            exp_v = {m_s == 1, m_s == 1 || m_s == 7, m_s == 6,
                     m_s == 3 || m_s == 4, m_s == 8, 4'(m_s)};
            act_v = {zeraN, zeraM, contaN, em_jogo, pronto, db_estado};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL model t=%0t got=%b want=%b", $time,
                         act_v, exp_v);
            end
        end
        if (contaN === 1'b1) n_conta++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(string nome, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nome, act, exp);
        end
    endtask

    task automatic mede_pausa(string nome);
        int n = 0;
        while (db_estado == 4'h4 && n < 20) begin
            n++;
            tick();
        end
        chk(nome, n, P);
    endtask

    task automatic espera(int est, int lim, string nome);
        int n = 0;
        while (db_estado != 4'(est) && n < lim) begin
            n++;
            tick();
        end
        chk(nome, int'(db_estado), est);
    endtask

    initial begin
        int c0;
        bit viu_prep;
        reset                 = 1'b1;
        iniciar               = 1'b0;
        nivel_concluido       = 1'b0;
        nivelIgualUltimoNivel = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("reset_outs", int'({zeraN, zeraM, contaN, em_jogo, pronto,
                                db_estado}), 0);

        // 1: start
        reset   = 1'b0;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("t1_prepara", int'(db_estado), 1);
        chk("t1_zera", int'({zeraN, zeraM}), 3);
        tick();
        chk("t1_jogando", int'(db_estado), 3);
        chk("t1_emjogo", int'(em_jogo), 1);

        // 2: level done, not last
        c0              = n_conta;
        nivel_concluido = 1'b1;
        tick();
        nivel_concluido = 1'b0;
        mede_pausa("t2_pausa_len");
        chk("t2_avalia", int'(db_estado), 5);
        tick();
        chk("t2_contaN", int'(contaN), 1);
        tick();
        chk("t2_recarrega_zeraM", int'({db_estado, zeraM}), 15);
        tick();
        chk("t2_volta", int'(db_estado), 3);
        chk("t2_npulsos", n_conta - c0, 1);

        // 3: last level
        c0                    = n_conta;
        nivelIgualUltimoNivel = 1'b1;
        nivel_concluido       = 1'b1;
        tick();
        nivel_concluido = 1'b0;
        mede_pausa("t3_pausa_len");
        tick();
        chk("t3_fim", int'({db_estado, pronto}), 17);
        repeat (3) tick();
        chk("t3_pronto_fica", int'(pronto), 1);
        chk("t3_sem_contaN", n_conta - c0, 0);
        nivelIgualUltimoNivel = 1'b0;
        iniciar               = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("t3_reinicia_zeraN", int'(zeraN), 1);
        tick();
        chk("t3_jogando", int'(db_estado), 3);

        // 4: reset in the middle of a pause
        nivel_concluido = 1'b1;
        tick();
        nivel_concluido = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_reset_outs", int'({zeraN, zeraM, contaN, em_jogo, pronto,
                                   db_estado}), 0);
        chk("t4_timer", int'(dut.u_pausa.contagem), 0);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        nivel_concluido = 1'b1;
        tick();
        nivel_concluido = 1'b0;
        mede_pausa("t4_pausa_len");
        espera(3, 10, "t4_volta");

        // 5: iniciar held, stray nivel_concluido in PAUSA/AVALIA
        c0              = n_conta;
        viu_prep        = 1'b0;
        iniciar         = 1'b1;
        nivel_concluido = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 4) nivel_concluido = 1'b0;
            if (db_estado == 4'h1) viu_prep = 1'b1;
        end
        iniciar = 1'b0;
        chk("t5_sem_prepara", int'(viu_prep), 0);
        chk("t5_um_contaN", n_conta - c0, 1);
        chk("t5_jogando", int'(db_estado), 3);

        // 6: full six-level run
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        c0 = n_conta;
        for (int lv = 0; lv < 10 && !pronto; lv++) begin
            nivelIgualUltimoNivel = (n_conta - c0) >= 5;
            nivel_concluido       = 1'b1;
            tick();
            nivel_concluido = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (db_estado == 4'h3 || db_estado == 4'h8) break;
                tick();
            end
        end
        chk("t6_pulsos", n_conta - c0, 5);
        chk("t6_pronto", int'(pronto), 1);

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
